// File: rtl/div_unit.sv
// Iterative restoring divider for MIPS DIV/DIVU. It produces {remainder, quotient}
// after WIDTH cycles and requests an E-stage stall for the whole divide.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 annul,
    output logic                 stall_req,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic               neg_q;
    logic               neg_r;
    logic [2*WIDTH-1:0] res_q;

    logic               accept;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               ge;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               done_now;

    // A zero divisor keeps the raw dividend and no sign flags, so the plain
    // restoring loop naturally yields {a, all ones}.
    always_comb begin
        accept  = (state == IDLE) && start && !annul;
        b_zero  = (b == '0);
        a_neg   = signed_div && a[WIDTH-1] && !b_zero;
        b_neg   = signed_div && b[WIDTH-1];
        a_mag   = a_neg ? (~a + 1'b1) : a;
        b_mag   = b_neg ? (~b + 1'b1) : b;
    end

    // The top bit of the wide subtract is the borrow, i.e. the compare result.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        ge      = !diff[WIDTH+1];
        rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ge};
    end

    always_comb begin
        q_fix    = neg_q ? (~quo + 1'b1) : quo;
        r_fix    = neg_r ? (~rem + 1'b1) : rem;
        done_now = (state == DONE) && !annul;
    end

    assign stall_req = accept || (state == BUSY);
    assign valid     = done_now;
    assign result    = done_now ? {r_fix, q_fix} : res_q;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= BUSY;
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                    end
                end
                BUSY: begin
                    if (annul) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!annul) begin
                        res_q <= {r_fix, q_fix};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus random divides, checked
// cycle by cycle against a plain-arithmetic reference.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_req;
    logic        valid;
    logic [63:0] result;
    logic [1:0]  fsm_state;

    int          total;
    int          bad;
    logic [63:0] last_result;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_req  (stall_req),
        .valid      (valid),
        .result     (result),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: 64-bit arithmetic division truncates toward zero, remainder
    // takes the dividend's sign; zero divisor gives {dividend, all ones}.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Starts at a negedge; annul_at < 0 means the divide runs to completion.
    task automatic run_div(input logic [31:0] da, input logic [31:0] db, input logic ds,
                           input int annul_at);
        logic [63:0] exp_r;
        logic        killed;
        exp_r  = ref_div(da, db, ds);
        killed = 1'b0;
        for (int n = 0; n <= 33; n++) begin
            if (n > 0) @(negedge clk);
            if (annul_at >= 0 && n > annul_at) killed = 1'b1;
            if (killed)       start = 1'b0;
            else if (n <= 32) start = 1'b1;
            else              start = 1'($urandom_range(0, 1));
            a          = da;
            b          = db;
            signed_div = ds;
            annul      = (n == annul_at);
            #1;
            if (killed) begin
                check_eq("stall_after_annul", 64'(stall_req), 64'd0);
                check_eq("valid_after_annul", 64'(valid), 64'd0);
                check_eq("result_kept_annul", result, last_result);
            end else if (n <= 32) begin
                check_eq("stall_busy", 64'(stall_req), 64'd1);
                check_eq("valid_busy", 64'(valid), 64'd0);
                check_eq("result_hold", result, last_result);
            end else begin
                check_eq("stall_done", 64'(stall_req), 64'd0);
                check_eq("valid_done", 64'(valid), 64'd1);
                check_eq("result_done", result, exp_r);
            end
        end
        @(negedge clk);
        start = 1'b0;
        annul = 1'b0;
        #1;
        if (annul_at < 0) last_result = exp_r;
        check_eq("valid_one_cycle", 64'(valid), 64'd0);
        check_eq("stall_idle", 64'(stall_req), 64'd0);
        check_eq("result_reg", result, last_result);
    endtask

    task automatic run_reset(input logic [31:0] da, input logic [31:0] db, input logic ds,
                             input int rst_at);
        for (int n = 0; n <= rst_at; n++) begin
            if (n > 0) @(negedge clk);
            start      = 1'b1;
            a          = da;
            b          = db;
            signed_div = ds;
            annul      = 1'b0;
            #1;
            check_eq("stall_pre_reset", 64'(stall_req), 64'd1);
        end
        rst   = 1'b0;
        start = 1'b0;
        #1;
        check_eq("stall_in_reset", 64'(stall_req), 64'd0);
        check_eq("valid_in_reset", 64'(valid), 64'd0);
        check_eq("result_in_reset", result, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_result = 64'd0;
        @(negedge clk);
        #1;
        check_eq("valid_after_reset", 64'(valid), 64'd0);
        check_eq("result_after_reset", result, 64'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        last_result = 64'd0;
        rst         = 1'b0;
        start       = 1'b0;
        signed_div  = 1'b0;
        a           = 32'd0;
        b           = 32'd0;
        annul       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_stall", 64'(stall_req), 64'd0);
        check_eq("reset_valid", 64'(valid), 64'd0);
        check_eq("reset_result", result, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        check_eq("ref_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        run_div(32'd100, 32'd7, 1'b0, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1);
        run_div(32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        run_div(32'h1234_5678, 32'd0, 1'b1, -1);
        run_div(32'h1234_5678, 32'd0, 1'b0, -1);
        run_div(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, -1);

        run_div(32'd1000, 32'd33, 1'b0, 10);
        run_div(32'd9, 32'd3, 1'b0, -1);
        run_div(32'hDEAD_BEEF, 32'd17, 1'b1, $urandom_range(1, 32));

        run_reset(32'hCAFE_0000, 32'd3, 1'b0, 20);
        run_div(32'd50, 32'd5, 1'b0, -1);

        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom();
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = -($urandom_range(1, 20));
                default: rb = $urandom();
            endcase
            run_div(ra, rb, 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
